// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus of the shared data-memory arbiter.
// slave = arbiter view, master = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic [1:0]          req_valid;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_ready;
    logic [1:0]          resp_valid;
    logic [DATA_W-1:0]   resp_rdata;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_read;
    logic                mem_write;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter serializing accesses to the shared 8x8 data memory:
// IDLE grants, ACCESS strobes the memory, RESP returns the response.
module mem_port_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic              busy,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

    state_e                  state_q, state_d;
    logic                    last_grant_q;
    logic                    owner_q;
    logic                    wr_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic [DATA_W-1:0]       mem_wdata_q;
    logic                    mem_read_q;
    logic                    mem_write_q;
    logic [1:0][CNT_W-1:0]   cnt_q;
    logic [1:0]              ready;
    logic                    gnt_id;
    logic                    accept;

    always_comb begin
        state_d = state_q;
        ready   = 2'b00;
        case (state_q)
            IDLE: begin
                case (bus.req_valid)
                    2'b01:   ready = 2'b01;
                    2'b10:   ready = 2'b10;
                    // tie goes to the port that did not win last time
                    2'b11:   ready = last_grant_q ? 2'b01 : 2'b10;
                    default: ready = 2'b00;
                endcase
                if (|bus.req_valid) state_d = ACCESS;
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign gnt_id = ready[1];
    assign accept = |ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            wr_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q      <= gnt_id;
                last_grant_q <= gnt_id;
                wr_q         <= bus.req_write[gnt_id];
                mem_addr_q   <= bus.req_addr[gnt_id*ADDR_W +: ADDR_W];
                mem_wdata_q  <= bus.req_wdata[gnt_id*DATA_W +: DATA_W];
                mem_write_q  <= bus.req_write[gnt_id];
                mem_read_q   <= ~bus.req_write[gnt_id];
            end else if (state_q == ACCESS) begin
                mem_addr_q  <= '0;
                mem_wdata_q <= '0;
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_cnt
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                cnt_q[p] <= '0;
            else if (ready[p] && cnt_q[p] != {CNT_W{1'b1}})
                cnt_q[p] <= cnt_q[p] + 1'b1;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.resp_rdata = (state_q == RESP && !wr_q) ? bus.mem_rdata : '0;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign busy           = (state_q != IDLE);
    assign grant_cnt0     = cnt_q[0];
    assign grant_cnt1     = cnt_q[1];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a memory model on the bus and a
// transaction-level reference (accept cycle + fixed latency) predicting every output.
module tb_mem_port_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [7:0] grant_cnt0, grant_cnt1;

    mem_port_arbiter_if #(.ADDR_W(3), .DATA_W(8)) bus ();

    mem_port_arbiter #(.ADDR_W(3), .DATA_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 clk = ~clk;

    // memory: sync write, registered read, write wins, shares the reset
    logic [7:0] ram [8];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) ram[i] <= 8'h00;
            bus.mem_rdata <= 8'h00;
        end else if (bus.mem_write) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end else if (bus.mem_read) begin
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    int tests = 0;
    int fails = 0;

    // reference state: a transaction accepted at t0 strobes at t0+1, responds at t0+2
    int         cyc, free_cyc, t0;
    bit         last;
    int         cnt [2];
    logic [7:0] mdl_mem [8];
    bit         t_own, t_wr;
    logic [2:0] t_addr;
    logic [7:0] t_data;

    // requester intent per port
    bit         pv [2];
    bit         pw [2];
    logic [2:0] pa [2];
    logic [7:0] pd [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_init();
        cyc = 0; free_cyc = 0; t0 = -10; last = 1'b1;
        cnt[0] = 0; cnt[1] = 0;
        t_own = 0; t_wr = 0; t_addr = 0; t_data = 0;
        for (int i = 0; i < 8; i++) mdl_mem[i] = 8'h00;
        for (int p = 0; p < 2; p++) begin pv[p] = 0; pw[p] = 0; pa[p] = 0; pd[p] = 0; end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req_valid = 2'b00; bus.req_write = 2'b00;
        bus.req_addr = '0; bus.req_wdata = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_cnt0", grant_cnt0, 0);
        chk("rst_cnt1", grant_cnt1, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_init();
    endtask

    // one clock: check registered outputs, drive requests, check the grant, advance model
    task automatic step();
        logic [1:0] ev;
        int g;
        @(posedge clk); #1;
        if (cyc == t0 + 2 && t_wr) mdl_mem[t_addr] = t_data;
        chk("busy", busy, cyc < free_cyc);
        chk("mem_write", bus.mem_write, (cyc == t0 + 1) && t_wr);
        chk("mem_read", bus.mem_read, (cyc == t0 + 1) && !t_wr);
        chk("mem_addr", bus.mem_addr, (cyc == t0 + 1) ? t_addr : 3'd0);
        chk("mem_wdata", bus.mem_wdata, (cyc == t0 + 1) ? t_data : 8'd0);
        chk("resp_valid", bus.resp_valid, (cyc == t0 + 2) ? (t_own ? 2'b10 : 2'b01) : 2'b00);
        chk("resp_rdata", bus.resp_rdata, (cyc == t0 + 2 && !t_wr) ? mdl_mem[t_addr] : 8'd0);
        chk("grant_cnt0", grant_cnt0, cnt[0]);
        chk("grant_cnt1", grant_cnt1, cnt[1]);
        for (int p = 0; p < 2; p++) begin
            bus.req_valid[p]         = pv[p];
            bus.req_write[p]         = pw[p];
            bus.req_addr[p*3 +: 3]   = pa[p];
            bus.req_wdata[p*8 +: 8]  = pd[p];
        end
        #1;
        ev = 2'b00;
        if (cyc >= free_cyc) begin
            if (pv[0] && pv[1]) ev = last ? 2'b01 : 2'b10;
            else if (pv[0])     ev = 2'b01;
            else if (pv[1])     ev = 2'b10;
        end
        chk("req_ready", bus.req_ready, ev);
        if (ev != 2'b00) begin
            g = ev[1] ? 1 : 0;
            t_own = ev[1]; t_wr = pw[g]; t_addr = pa[g]; t_data = pd[g];
            t0 = cyc; free_cyc = cyc + 3; last = ev[1];
            if (cnt[g] < 255) cnt[g]++;
            pv[g] = 0;
        end
        cyc++;
    endtask

    task automatic run_rand(input int n, input bit [1:0] mask, input int pnew, input int pdrop);
        repeat (n) begin
            for (int p = 0; p < 2; p++) begin
                if (mask[p]) begin
                    if (pv[p]) begin
                        if (int'($urandom_range(99)) < pdrop) pv[p] = 0;
                    end else if (int'($urandom_range(99)) < pnew) begin
                        pv[p] = 1;
                        pw[p] = 1'($urandom_range(1));
                        pa[p] = 3'($urandom_range(7));
                        pd[p] = 8'($urandom_range(255));
                    end
                end
            end
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        model_init();
        #2;
        do_reset();

        // port 0 writes A5 to addr 3, then port 1 reads it back
        pv[0] = 1; pw[0] = 1; pa[0] = 3'd3; pd[0] = 8'hA5;
        repeat (4) step();
        chk("cnt0_after_write", grant_cnt0, 1);
        pv[1] = 1; pw[1] = 0; pa[1] = 3'd3; pd[1] = 8'h00;
        repeat (4) step();

        // both ports saturated with requests: strict alternation from port 0
        do_reset();
        run_rand(12, 2'b11, 100, 0);

        // port 0 raises a request during a port-1 access and withdraws it
        pv[1] = 1; pw[1] = 0; pa[1] = 3'd5; pd[1] = 8'h00;
        step();
        pv[0] = 1; pw[0] = 1; pa[0] = 3'd2; pd[0] = 8'h3C;
        step();
        step();
        pv[0] = 0;
        repeat (4) step();

        // reset in the ACCESS cycle of a write drops it; next tie goes to port 0
        pv[0] = 1; pw[0] = 1; pa[0] = 3'd6; pd[0] = 8'h77;
        step();
        @(posedge clk); #1;
        chk("access_strobe", bus.mem_write, 1);
        do_reset();
        run_rand(9, 2'b11, 100, 0);

        // random traffic with withdrawals
        run_rand(1500, 2'b11, 40, 15);

        // single port saturates its counter
        do_reset();
        run_rand(910, 2'b01, 100, 0);
        chk("cnt0_saturated", grant_cnt0, 255);
        chk("cnt1_idle", grant_cnt1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
